// File: rtl/can_tx_sched_if.sv
// Mailbox-side and can_tx-side signals of the CAN transmit scheduler.
// The scheduler connects through the slave modport; the host/bus model
// driving it uses the master modport.
interface can_tx_sched_if #(
  parameter int NUM_MB = 4,
  parameter int ID_W   = 11
);
  localparam int SEL_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

  logic [NUM_MB-1:0]      i_Req;
  logic [NUM_MB*ID_W-1:0] i_Id;
  logic                   i_Bus_Idle;
  logic                   i_Tx_Done;
  logic                   i_Arb_Lost;
  logic                   i_Tx_Err;
  logic                   o_Tx_DV;
  logic [SEL_W-1:0]       o_Tx_Sel;
  logic [NUM_MB-1:0]      o_Grant;
  logic [NUM_MB-1:0]      o_Done;
  logic [NUM_MB-1:0]      o_Fail;
  logic                   o_Busy;

  modport slave (
    input  i_Req, i_Id, i_Bus_Idle, i_Tx_Done, i_Arb_Lost, i_Tx_Err,
    output o_Tx_DV, o_Tx_Sel, o_Grant, o_Done, o_Fail, o_Busy
  );

  modport master (
    output i_Req, i_Id, i_Bus_Idle, i_Tx_Done, i_Arb_Lost, i_Tx_Err,
    input  o_Tx_DV, o_Tx_Sel, o_Grant, o_Done, o_Fail, o_Busy
  );
endinterface

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: picks the pending mailbox with the lowest
// identifier, waits out the interframe space, launches can_tx and resolves
// the outcome (done / error with bounded retry / lost arbitration).
module can_tx_sched #(
  parameter int NUM_MB       = 4,
  parameter int ID_W         = 11,
  parameter int CLKS_PER_BIT = 10,
  parameter int IFS_BITS     = 3,
  parameter int RETRY_MAX    = 16
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  can_tx_sched_if.slave  bus
);

  localparam int SEL_W    = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam int IFS_CLKS = IFS_BITS * CLKS_PER_BIT;
  localparam int ICNT_W   = (IFS_CLKS > 1) ? $clog2(IFS_CLKS) : 1;
  localparam int RCNT_W   = $clog2(RETRY_MAX + 1);

  localparam logic [ICNT_W-1:0] IFS_LAST   = ICNT_W'(IFS_CLKS - 1);
  localparam logic [RCNT_W-1:0] RETRY_LAST = RCNT_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_WAIT_BUS,
    S_LAUNCH,
    S_ACTIVE
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [ICNT_W-1:0]  idle_cnt, idle_cnt_nxt;
  logic [RCNT_W-1:0]  retry, retry_nxt, retry_inc;
  logic               tx_dv, tx_dv_nxt;
  logic [NUM_MB-1:0]  grant, grant_nxt;
  logic [NUM_MB-1:0]  done, done_nxt;
  logic [NUM_MB-1:0]  fail, fail_nxt;
  logic               busy, busy_nxt;

  logic               found;
  logic [SEL_W-1:0]   best_idx;
  logic [ID_W-1:0]    best_id;

  // Lowest-ID requester; strict '<' keeps the lowest index on equal IDs.
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_id  = '1;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (bus.i_Req[i] && (!found || (bus.i_Id[i*ID_W +: ID_W] < best_id))) begin
        found    = 1'b1;
        best_idx = SEL_W'(i);
        best_id  = bus.i_Id[i*ID_W +: ID_W];
      end
    end
  end

  // Saturating increment; the counter is cleared on reaching RETRY_MAX,
  // so saturation only guards against an out-of-range state.
  always_comb begin
    retry_inc = (retry == RETRY_LAST) ? retry : retry + 1'b1;
  end

  // Next-state logic plus next values of the registered outputs.
  // Outputs are computed from the next state so that they register in
  // the same edge as the transition (e.g. o_Done alongside return to IDLE).
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    idle_cnt_nxt = idle_cnt;
    retry_nxt    = retry;
    done_nxt     = '0;
    fail_nxt     = '0;

    case (state)
      S_IDLE: begin
        if (|bus.i_Req) state_nxt = S_PICK;
      end

      S_PICK: begin
        if (!found) begin
          state_nxt = S_IDLE;
        end else begin
          sel_nxt      = best_idx;
          idle_cnt_nxt = '0;
          state_nxt    = S_WAIT_BUS;
          if (best_idx != sel) retry_nxt = '0;
        end
      end

      S_WAIT_BUS: begin
        if (!bus.i_Req[sel]) begin
          state_nxt = S_IDLE;
        end else if (!bus.i_Bus_Idle) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IFS_LAST) begin
          state_nxt = S_LAUNCH;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end

      S_LAUNCH: begin
        state_nxt = S_ACTIVE;
      end

      S_ACTIVE: begin
        if (bus.i_Tx_Done) begin
          done_nxt[sel] = 1'b1;
          retry_nxt     = '0;
          state_nxt     = S_IDLE;
        end else if (bus.i_Tx_Err) begin
          if (retry_inc == RETRY_LAST) begin
            fail_nxt[sel] = 1'b1;
            retry_nxt     = '0;
            state_nxt     = S_IDLE;
          end else begin
            retry_nxt = retry_inc;
            state_nxt = S_PICK;
          end
        end else if (bus.i_Arb_Lost) begin
          state_nxt = S_PICK;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    tx_dv_nxt = (state_nxt == S_LAUNCH);
    busy_nxt  = (state_nxt != S_IDLE);
    grant_nxt = '0;
    if ((state_nxt == S_WAIT_BUS) || (state_nxt == S_LAUNCH) || (state_nxt == S_ACTIVE))
      grant_nxt[sel_nxt] = 1'b1;
  end

  // State, counters, selection and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= S_IDLE;
      sel      <= '0;
      idle_cnt <= '0;
      retry    <= '0;
      tx_dv    <= 1'b0;
      grant    <= '0;
      done     <= '0;
      fail     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      idle_cnt <= idle_cnt_nxt;
      retry    <= retry_nxt;
      tx_dv    <= tx_dv_nxt;
      grant    <= grant_nxt;
      done     <= done_nxt;
      fail     <= fail_nxt;
      busy     <= busy_nxt;
    end
  end

  assign bus.o_Tx_DV  = tx_dv;
  assign bus.o_Tx_Sel = sel;
  assign bus.o_Grant  = grant;
  assign bus.o_Done   = done;
  assign bus.o_Fail   = fail;
  assign bus.o_Busy   = busy;

endmodule

// File: tb/tb_can_tx_sched.sv
// Scoreboard bench for can_tx_sched: stimulus pushes expected launch /
// done / fail events with their cycle; a negedge monitor pops and compares.
module tb_can_tx_sched;
  localparam int NUM_MB = 4;
  localparam int ID_W   = 11;

  localparam logic [1:0] K_DV   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_FAIL = 2'd2;

  logic i_Clock = 1'b0;
  logic i_Reset;

  can_tx_sched_if #(.NUM_MB(NUM_MB), .ID_W(ID_W)) bus ();

  can_tx_sched #(
    .NUM_MB(NUM_MB), .ID_W(ID_W), .CLKS_PER_BIT(10), .IFS_BITS(3), .RETRY_MAX(16)
  ) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .bus(bus)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  vec;
    logic [1:0]  sel;
    logic [31:0] cyc;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] v, input logic [1:0] s, input int c);
    ev_t e;
    e.kind = k;
    e.vec  = v;
    e.sel  = s;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  always @(negedge i_Clock) begin
    ev_t o;
    ev_t e;
    if (bus.o_Tx_DV || (|bus.o_Done) || (|bus.o_Fail)) begin
      o.kind = bus.o_Tx_DV ? K_DV : ((|bus.o_Done) ? K_DONE : K_FAIL);
      o.vec  = bus.o_Tx_DV ? bus.o_Grant : ((|bus.o_Done) ? bus.o_Done : bus.o_Fail);
      o.sel  = bus.o_Tx_Sel;
      o.cyc  = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %0h expected none", o);
      end else begin
        e = sb.pop_front();
        check("scoreboard_event", 64'(o), 64'(e));
      end
    end
  end

  // Waits for the launch strobe, then one more cycle so the DUT is ACTIVE.
  task automatic wait_dv(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge i_Clock);
      if (bus.o_Tx_DV) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no o_Tx_DV expected one within 400 cycles", name);
    end
    @(negedge i_Clock);
  endtask

  // Successful completion of the active mailbox; the host drops its request.
  task automatic finish_done(input logic [3:0] mask, input logic [1:0] s);
    bus.i_Tx_Done = 1'b1;
    push(K_DONE, mask, s, cyc + 1);
    @(negedge i_Clock);
    bus.i_Tx_Done = 1'b0;
    bus.i_Req     = bus.i_Req & ~mask;
    check("busy_after_done", 64'(bus.o_Busy), 64'(0));
    check("grant_after_done", 64'(bus.o_Grant), 64'(0));
    check("sel_hold_idle", 64'(bus.o_Tx_Sel), 64'(s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1);
  end

  initial begin
    i_Reset        = 1'b1;
    bus.i_Req      = '0;
    bus.i_Id       = '0;
    bus.i_Bus_Idle = 1'b1;
    bus.i_Tx_Done  = 1'b0;
    bus.i_Arb_Lost = 1'b0;
    bus.i_Tx_Err   = 1'b0;
    repeat (3) @(negedge i_Clock);
    check("rst_dv",    64'(bus.o_Tx_DV),  64'(0));
    check("rst_grant", 64'(bus.o_Grant),  64'(0));
    check("rst_done",  64'(bus.o_Done),   64'(0));
    check("rst_fail",  64'(bus.o_Fail),   64'(0));
    check("rst_busy",  64'(bus.o_Busy),   64'(0));
    check("rst_sel",   64'(bus.o_Tx_Sel), 64'(0));
    i_Reset = 1'b0;
    @(negedge i_Clock);

    // Single request
    bus.i_Id[0*ID_W +: ID_W] = 11'h123;
    bus.i_Req = 4'b0001;
    push(K_DV, 4'b0001, 2'd0, cyc + 32);
    wait_dv("single");
    check("busy_active", 64'(bus.o_Busy), 64'(1));
    finish_done(4'b0001, 2'd0);

    // Priority: mailbox 1 has the lower ID
    bus.i_Id[1*ID_W +: ID_W] = 11'h0F0;
    bus.i_Req = 4'b0011;
    push(K_DV, 4'b0010, 2'd1, cyc + 32);
    wait_dv("prio_first");
    finish_done(4'b0010, 2'd1);
    push(K_DV, 4'b0001, 2'd0, cyc + 32);
    wait_dv("prio_second");
    finish_done(4'b0001, 2'd0);

    // Tie: lowest index wins
    bus.i_Id[0*ID_W +: ID_W] = 11'h200;
    bus.i_Id[1*ID_W +: ID_W] = 11'h200;
    bus.i_Req = 4'b0011;
    push(K_DV, 4'b0001, 2'd0, cyc + 32);
    wait_dv("tie_first");
    finish_done(4'b0001, 2'd0);
    push(K_DV, 4'b0010, 2'd1, cyc + 32);
    wait_dv("tie_second");
    finish_done(4'b0010, 2'd1);

    // Arbitration loss with a higher-priority request arriving mid-frame
    bus.i_Id[2*ID_W +: ID_W] = 11'h300;
    bus.i_Id[3*ID_W +: ID_W] = 11'h010;
    bus.i_Req = 4'b0100;
    push(K_DV, 4'b0100, 2'd2, cyc + 32);
    wait_dv("arb_first");
    bus.i_Req = 4'b1100;
    @(negedge i_Clock);
    bus.i_Arb_Lost = 1'b1;
    push(K_DV, 4'b1000, 2'd3, cyc + 32);
    @(negedge i_Clock);
    bus.i_Arb_Lost = 1'b0;
    wait_dv("arb_relaunch");
    finish_done(4'b1000, 2'd3);
    push(K_DV, 4'b0100, 2'd2, cyc + 32);
    wait_dv("arb_mb2");
    finish_done(4'b0100, 2'd2);

    // Error retry: 16 launches then failure
    bus.i_Id[0*ID_W +: ID_W] = 11'h123;
    bus.i_Req = 4'b0001;
    push(K_DV, 4'b0001, 2'd0, cyc + 32);
    for (int k = 0; k < 16; k++) begin
      wait_dv("retry");
      bus.i_Tx_Err = 1'b1;
      if (k < 15) push(K_DV, 4'b0001, 2'd0, cyc + 32);
      else        push(K_FAIL, 4'b0001, 2'd0, cyc + 1);
      @(negedge i_Clock);
      bus.i_Tx_Err = 1'b0;
    end
    bus.i_Req = 4'b0000;
    check("busy_after_fail", 64'(bus.o_Busy), 64'(0));

    // Simultaneous done and error: done wins
    @(negedge i_Clock);
    bus.i_Req = 4'b0001;
    push(K_DV, 4'b0001, 2'd0, cyc + 32);
    wait_dv("done_err");
    bus.i_Tx_Err = 1'b1;
    finish_done(4'b0001, 2'd0);
    bus.i_Tx_Err = 1'b0;

    // Bus goes busy at idle count 25: counter restarts
    bus.i_Req = 4'b0001;
    push(K_DV, 4'b0001, 2'd0, cyc + 58);
    repeat (27) @(negedge i_Clock);
    bus.i_Bus_Idle = 1'b0;
    @(negedge i_Clock);
    bus.i_Bus_Idle = 1'b1;
    wait_dv("bus_busy");
    finish_done(4'b0001, 2'd0);

    // Withdrawal in WAIT_BUS: no launch, no pulses
    bus.i_Req = 4'b0001;
    repeat (10) @(negedge i_Clock);
    check("busy_wait", 64'(bus.o_Busy), 64'(1));
    check("grant_wait", 64'(bus.o_Grant), 64'(1));
    bus.i_Req = 4'b0000;
    repeat (40) @(negedge i_Clock);
    check("busy_withdrawn", 64'(bus.o_Busy), 64'(0));
    check("grant_withdrawn", 64'(bus.o_Grant), 64'(0));

    // Reset mid-frame, request held across reset
    bus.i_Req = 4'b0100;
    push(K_DV, 4'b0100, 2'd2, cyc + 32);
    wait_dv("pre_reset");
    check("sel_active", 64'(bus.o_Tx_Sel), 64'(2));
    i_Reset = 1'b1;
    @(negedge i_Clock);
    check("mid_rst_dv",    64'(bus.o_Tx_DV),  64'(0));
    check("mid_rst_grant", 64'(bus.o_Grant),  64'(0));
    check("mid_rst_busy",  64'(bus.o_Busy),   64'(0));
    check("mid_rst_sel",   64'(bus.o_Tx_Sel), 64'(0));
    check("mid_rst_done",  64'(bus.o_Done),   64'(0));
    check("mid_rst_fail",  64'(bus.o_Fail),   64'(0));
    i_Reset = 1'b0;
    push(K_DV, 4'b0100, 2'd2, cyc + 32);
    wait_dv("post_reset");
    finish_done(4'b0100, 2'd2);

    repeat (5) @(negedge i_Clock);
    check("queue_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
